// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and the memory (slave).
// Request side is valid/grant: the master holds req and payload until gnt; rvalid returns load data.
interface mem_stage_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: forms byte enables/store lanes, runs the dmem handshake, extends load data.
// Latency: non-mem 1 edge; store >= 3 edges; load >= 4 edges (gnt and rvalid dependent).
// Backpressure: stall_in freezes output registers; stall_out holds stages 1-3 while an access is busy.
module mem_stage #(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall_in,
    output logic             stall_out,
    input  logic             valid_in,
    input  logic [1:0]       mem_op,
    input  logic [1:0]       mem_size,
    input  logic             mem_unsigned,
    input  logic [XLEN-1:0]  eval,
    input  logic [XLEN-1:0]  store_data,
    input  logic [REG_W-1:0] rd_in,
    mem_stage_if.master      dmem,
    output logic             valid_out,
    output logic [XLEN-1:0]  result,
    output logic [REG_W-1:0] rd_out,
    output logic             misaligned
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;

    logic [1:0]       state;
    logic             req_q;
    logic             we_q;
    logic [XLEN-1:0]  addr_q;
    logic [3:0]       be_q;
    logic [XLEN-1:0]  wdata_q;
    logic [1:0]       lo_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [XLEN-1:0]  buf_q;
    logic [REG_W-1:0] rd_q;

    logic             is_mem;
    logic             mis_c;
    logic [3:0]       be_c;
    logic [XLEN-1:0]  wdata_c;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  load_ext;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

    assign stall_out = stall_in | (state != IDLE);

    // Reserved op 2'b11 falls through as a non-memory instruction.
    assign is_mem = (mem_op == OP_LOAD) || (mem_op == OP_STORE);
    // Size 2'b11 is handled as a word everywhere.
    assign mis_c  = ((mem_size == SZ_HALF) && eval[0]) || (mem_size[1] && (eval[1:0] != 2'b00));

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = store_data;
        case (mem_size)
            SZ_BYTE: begin
                be_c    = 4'b0001 << eval[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be_c    = 4'b0011 << {eval[1], 1'b0};
                wdata_c = {2{store_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = store_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem.dmem_rdata[7:0];
        case (lo_q)
            2'd0:    ld_byte = dmem.dmem_rdata[7:0];
            2'd1:    ld_byte = dmem.dmem_rdata[15:8];
            2'd2:    ld_byte = dmem.dmem_rdata[23:16];
            default: ld_byte = dmem.dmem_rdata[31:24];
        endcase
        ld_half = lo_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_ext = {{(XLEN-8){~uns_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: load_ext = {{(XLEN-16){~uns_q & ld_half[15]}}, ld_half};
            default: load_ext = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= '0;
            lo_q       <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            buf_q      <= '0;
            rd_q       <= '0;
            valid_out  <= 1'b0;
            result     <= '0;
            rd_out     <= '0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!stall_in) begin
                        if (!valid_in || !is_mem) begin
                            valid_out  <= valid_in;
                            result     <= eval;
                            rd_out     <= rd_in;
                            misaligned <= 1'b0;
                        end else if (mis_c) begin
                            valid_out  <= 1'b1;
                            result     <= eval;
                            rd_out     <= rd_in;
                            misaligned <= 1'b1;
                        end else begin
                            req_q      <= 1'b1;
                            we_q       <= (mem_op == OP_STORE);
                            addr_q     <= {eval[XLEN-1:2], 2'b00};
                            be_q       <= be_c;
                            wdata_q    <= wdata_c;
                            lo_q       <= eval[1:0];
                            size_q     <= mem_size;
                            uns_q      <= mem_unsigned;
                            // Stores report the address as their result; loads overwrite this in RESP.
                            buf_q      <= eval;
                            rd_q       <= rd_in;
                            valid_out  <= 1'b0;
                            misaligned <= 1'b0;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_gnt) begin
                        req_q <= 1'b0;
                        state <= we_q ? DONE : RESP;
                    end
                end
                RESP: begin
                    if (dmem.dmem_rvalid) begin
                        buf_q <= load_ext;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!stall_in) begin
                        valid_out <= 1'b1;
                        result    <= buf_q;
                        rd_out    <= rd_q;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, randomized ops against an arithmetic reference
// model, and hand sequences for IDLE stall hold and reset during an outstanding load.
module tb_mem_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall_in;
    logic        stall_out;
    logic        valid_in;
    logic [1:0]  mem_op;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] eval;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        valid_out;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        misaligned;

    mem_stage_if #(.XLEN(32)) dmem ();

    mem_stage #(.XLEN(32), .REG_W(5)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .stall_in     (stall_in),
        .stall_out    (stall_out),
        .valid_in     (valid_in),
        .mem_op       (mem_op),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .eval         (eval),
        .store_data   (store_data),
        .rd_in        (rd_in),
        .dmem         (dmem.master),
        .valid_out    (valid_out),
        .result       (result),
        .rd_out       (rd_out),
        .misaligned   (misaligned)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        vld;
        logic [1:0]  op;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] ev;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          gd;
        int          rvd;
        int          st;
        logic [31:0] x_res;
        logic [3:0]  x_be;
        logic [31:0] x_wd;
        logic        x_mis;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic vld, input logic [1:0] op, input logic [1:0] size,
                                 input logic uns, input logic [31:0] ev, input logic [31:0] sd,
                                 input logic [31:0] rdata, input logic [4:0] rd, input int gd,
                                 input int rvd, input int st, input logic [31:0] x_res,
                                 input logic [3:0] x_be, input logic [31:0] x_wd, input logic x_mis);
        vec_t v;
        v.vld = vld; v.op = op; v.size = size; v.uns = uns; v.ev = ev; v.sd = sd;
        v.rdata = rdata; v.rd = rd; v.gd = gd; v.rvd = rvd; v.st = st;
        v.x_res = x_res; v.x_be = x_be; v.x_wd = x_wd; v.x_mis = x_mis;
        return v;
    endfunction

    // Reference: access width n bytes, offset in word, plain shifts/masks on 64-bit integers.
    function automatic vec_t model(input vec_t vi);
        vec_t        v;
        int          off;
        int          n;
        longint      mask;
        logic [31:0] lane;
        logic [31:0] wd;
        logic [31:0] val;
        logic        memop;
        v     = vi;
        off   = int'(v.ev[1:0]);
        n     = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        mask  = (longint'(1) << (8 * n)) - 1;
        memop = v.vld && (v.op == 2'd1 || v.op == 2'd2);
        v.x_mis = memop && ((off % n) != 0);
        v.x_be  = 4'(((1 << n) - 1) << (off - off % n));
        lane = 32'(longint'(v.sd) & mask);
        wd   = 32'd0;
        for (int i = 0; i < 4; i += n) wd = wd | 32'(longint'(lane) << (8 * i));
        v.x_wd = wd;
        val = 32'((longint'(v.rdata) >> (8 * off)) & mask);
        if (!v.uns && n < 4 && val[8*n-1]) val = 32'(longint'(val) - (longint'(1) << (8 * n)));
        v.x_res = (memop && v.op == 2'd1 && !v.x_mis) ? val : v.ev;
        return v;
    endfunction

    task automatic run(input vec_t v, input string tag);
        logic req_path;
        logic is_ld;
        req_path = v.vld && (v.op == 2'd1 || v.op == 2'd2) && !v.x_mis;
        is_ld    = (v.op == 2'd1);
        valid_in = v.vld; mem_op = v.op; mem_size = v.size; mem_unsigned = v.uns;
        eval = v.ev; store_data = v.sd; rd_in = v.rd;
        @(posedge clock); #1;
        if (!req_path) begin
            chk({tag, ".valid_out"}, 32'(valid_out), 32'(v.vld));
            chk({tag, ".result"}, result, v.x_res);
            chk({tag, ".rd_out"}, 32'(rd_out), 32'(v.rd));
            if (v.vld) chk({tag, ".misaligned"}, 32'(misaligned), 32'(v.x_mis));
            chk({tag, ".no_req"}, 32'(dmem.dmem_req), 32'd0);
            chk({tag, ".stall_out_idle"}, 32'(stall_out), 32'd0);
            valid_in = 1'b0;
        end else begin
            // Garbage on stage-3 inputs while busy must be ignored.
            valid_in = 1'b1; mem_op = 2'($urandom_range(3)); mem_size = 2'($urandom_range(3));
            eval = $urandom; store_data = $urandom; rd_in = 5'($urandom_range(31));
            chk({tag, ".req"}, 32'(dmem.dmem_req), 32'd1);
            chk({tag, ".we"}, 32'(dmem.dmem_we), 32'(!is_ld));
            chk({tag, ".addr"}, dmem.dmem_addr, {v.ev[31:2], 2'b00});
            chk({tag, ".be"}, 32'(dmem.dmem_be), 32'(v.x_be));
            chk({tag, ".wdata"}, dmem.dmem_wdata, v.x_wd);
            chk({tag, ".stall_out"}, 32'(stall_out), 32'd1);
            chk({tag, ".valid_out_busy"}, 32'(valid_out), 32'd0);
            repeat (v.gd) begin
                @(posedge clock); #1;
                chk({tag, ".req_hold"}, 32'(dmem.dmem_req), 32'd1);
                chk({tag, ".be_hold"}, 32'(dmem.dmem_be), 32'(v.x_be));
                chk({tag, ".wdata_hold"}, dmem.dmem_wdata, v.x_wd);
                chk({tag, ".stall_hold"}, 32'(stall_out), 32'd1);
            end
            dmem.dmem_gnt = 1'b1;
            if (is_ld) begin
                dmem.dmem_rvalid = 1'b1;
                dmem.dmem_rdata  = ~v.rdata;
            end
            @(posedge clock); #1;
            dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0;
            chk({tag, ".req_drop"}, 32'(dmem.dmem_req), 32'd0);
            if (is_ld) begin
                repeat (v.rvd) begin
                    @(posedge clock); #1;
                    chk({tag, ".wait_rv"}, 32'(valid_out), 32'd0);
                end
                dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = v.rdata;
                @(posedge clock); #1;
                dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = $urandom;
            end
            chk({tag, ".stall_done"}, 32'(stall_out), 32'd1);
            stall_in = (v.st > 0);
            repeat (v.st) begin
                @(posedge clock); #1;
                chk({tag, ".done_held"}, 32'(valid_out), 32'd0);
                chk({tag, ".done_stall"}, 32'(stall_out), 32'd1);
            end
            stall_in = 1'b0;
            @(posedge clock); #1;
            chk({tag, ".valid_out"}, 32'(valid_out), 32'd1);
            chk({tag, ".result"}, result, v.x_res);
            chk({tag, ".rd_out"}, 32'(rd_out), 32'(v.rd));
            chk({tag, ".misaligned"}, 32'(misaligned), 32'd0);
            chk({tag, ".stall_release"}, 32'(stall_out), 32'd0);
            valid_in = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t v;

        reset_n = 1'b0; stall_in = 1'b0; valid_in = 1'b0; mem_op = 2'b00; mem_size = 2'b00;
        mem_unsigned = 1'b0; eval = '0; store_data = '0; rd_in = '0;
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst.valid_out", 32'(valid_out), 32'd0);
        chk("rst.req", 32'(dmem.dmem_req), 32'd0);
        chk("rst.we", 32'(dmem.dmem_we), 32'd0);
        chk("rst.be", 32'(dmem.dmem_be), 32'd0);
        chk("rst.addr", dmem.dmem_addr, 32'd0);
        chk("rst.wdata", dmem.dmem_wdata, 32'd0);
        chk("rst.result", result, 32'd0);
        chk("rst.rd_out", 32'(rd_out), 32'd0);
        chk("rst.misaligned", 32'(misaligned), 32'd0);
        chk("rst.stall_out", 32'(stall_out), 32'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        //            vld op    size  uns ev          sd            rdata         rd gd rv st  x_res         x_be     x_wd          mis
        tbl.push_back(mkv(1, 2'd0, 2'd2, 0, 32'h1234,   32'h0,        32'h0,        5, 0, 0, 0, 32'h1234,     4'b0000, 32'h0,        0));
        tbl.push_back(mkv(1, 2'd1, 2'd0, 0, 32'h103,    32'h0,        32'h80FF0000, 1, 0, 0, 0, 32'hFFFFFF80, 4'b1000, 32'h0,        0));
        tbl.push_back(mkv(1, 2'd2, 2'd1, 0, 32'h202,    32'hABCD,     32'h0,        2, 3, 0, 0, 32'h202,      4'b1100, 32'hABCDABCD, 0));
        tbl.push_back(mkv(1, 2'd1, 2'd2, 0, 32'h301,    32'h0,        32'h0,        3, 0, 0, 0, 32'h301,      4'b0000, 32'h0,        1));
        tbl.push_back(mkv(1, 2'd1, 2'd0, 1, 32'h103,    32'h0,        32'h80FF0000, 4, 0, 1, 0, 32'h80,       4'b1000, 32'h0,        0));
        tbl.push_back(mkv(1, 2'd1, 2'd1, 0, 32'h102,    32'h0,        32'h80011234, 6, 1, 2, 0, 32'hFFFF8001, 4'b1100, 32'h0,        0));
        tbl.push_back(mkv(1, 2'd1, 2'd1, 1, 32'h102,    32'h0,        32'h80011234, 7, 0, 0, 0, 32'h00008001, 4'b1100, 32'h0,        0));
        tbl.push_back(mkv(1, 2'd1, 2'd1, 0, 32'h100,    32'h0,        32'h80011234, 8, 0, 0, 0, 32'h00001234, 4'b0011, 32'h0,        0));
        tbl.push_back(mkv(1, 2'd1, 2'd2, 1, 32'h40,     32'h0,        32'hDEADBEEF, 9, 0, 0, 2, 32'hDEADBEEF, 4'b1111, 32'h0,        0));
        tbl.push_back(mkv(1, 2'd2, 2'd0, 0, 32'h1,      32'h12345678, 32'h0,       10, 1, 0, 1, 32'h1,        4'b0010, 32'h78787878, 0));
        tbl.push_back(mkv(1, 2'd2, 2'd2, 0, 32'h8,      32'hCAFEF00D, 32'h0,       11, 0, 0, 0, 32'h8,        4'b1111, 32'hCAFEF00D, 0));
        tbl.push_back(mkv(1, 2'd2, 2'd1, 0, 32'h203,    32'h5555,     32'h0,       12, 0, 0, 0, 32'h203,      4'b0000, 32'h0,        1));
        tbl.push_back(mkv(1, 2'd3, 2'd2, 0, 32'h55,     32'h0,        32'h0,       13, 0, 0, 0, 32'h55,       4'b0000, 32'h0,        0));
        tbl.push_back(mkv(0, 2'd1, 2'd2, 0, 32'h77,     32'h0,        32'h0,       14, 0, 0, 0, 32'h77,       4'b0000, 32'h0,        0));
        tbl.push_back(mkv(1, 2'd1, 2'd0, 0, 32'h102,    32'h0,        32'h007F0000,15, 0, 0, 0, 32'h7F,       4'b0100, 32'h0,        0));
        tbl.push_back(mkv(1, 2'd1, 2'd1, 1, 32'h101,    32'h0,        32'h0,       16, 0, 0, 0, 32'h101,      4'b0000, 32'h0,        1));

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // IDLE with stall_in: outputs hold and no request launches.
        run(mkv(1, 2'd0, 2'd0, 0, 32'hAAAA0001, 32'h0, 32'h0, 7, 0, 0, 0, 32'hAAAA0001, 4'b0, 32'h0, 0), "pre_stall");
        stall_in = 1'b1; valid_in = 1'b1; mem_op = 2'd1; mem_size = 2'd2; eval = 32'h5550; rd_in = 5'd9;
        repeat (2) @(posedge clock);
        #1;
        chk("idle_stall.result", result, 32'hAAAA0001);
        chk("idle_stall.rd_out", 32'(rd_out), 32'd7);
        chk("idle_stall.valid_out", 32'(valid_out), 32'd1);
        chk("idle_stall.no_req", 32'(dmem.dmem_req), 32'd0);
        chk("idle_stall.stall_out", 32'(stall_out), 32'd1);
        stall_in = 1'b0; valid_in = 1'b0;
        @(posedge clock); #1;

        // Reset while a load waits in RESP.
        valid_in = 1'b1; mem_op = 2'd1; mem_size = 2'd2; eval = 32'h10; rd_in = 5'd3;
        @(posedge clock); #1;
        valid_in = 1'b0; dmem.dmem_gnt = 1'b1;
        @(posedge clock); #1;
        dmem.dmem_gnt = 1'b0;
        chk("rst_resp.pre_stall", 32'(stall_out), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_resp.req", 32'(dmem.dmem_req), 32'd0);
        chk("rst_resp.valid_out", 32'(valid_out), 32'd0);
        chk("rst_resp.stall_out", 32'(stall_out), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = 32'hBAD0BAD0;
        @(posedge clock); #1;
        dmem.dmem_rvalid = 1'b0;
        chk("rst_resp.stray_rv", 32'(valid_out), 32'd0);
        run(mkv(1, 2'd0, 2'd0, 0, 32'h4321, 32'h0, 32'h0, 21, 0, 0, 0, 32'h4321, 4'b0, 32'h0, 0), "post_rst");

        // Randomized operations against the reference model.
        for (int k = 0; k < 200; k++) begin
            v.vld   = ($urandom_range(7) != 0);
            v.op    = 2'($urandom_range(3));
            v.size  = 2'($urandom_range(2));
            v.uns   = 1'($urandom_range(1));
            v.ev    = $urandom;
            v.sd    = $urandom;
            v.rdata = $urandom;
            v.rd    = 5'($urandom_range(31));
            v.gd    = $urandom_range(3);
            v.rvd   = $urandom_range(2);
            v.st    = ($urandom_range(2) == 0) ? $urandom_range(2) : 0;
            v = model(v);
            run(v, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
